// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the async-read ROM and registers the
// returned word into the IF/ID pipeline register. Supports stall, redirect and sticky halt.
module fetch_unit #(
  parameter int unsigned    AW        = 8,
  parameter int unsigned    DW        = 16,
  parameter logic [AW-1:0]  RESET_PC  = 8'h00,
  parameter logic [DW-1:0]  HALT_WORD = 16'hEFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  input  logic          stall,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [DW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  output logic          if_valid,
  output logic          halted
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] if_instr_q, if_instr_d;
  logic [AW-1:0] if_pc_q, if_pc_d;
  logic          if_valid_q, if_valid_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;

    unique case (state_q)
      StRun: begin
        if (redirect) begin
          // Redirect beats stall and suppresses the halt check on the current word.
          pc_d       = redirect_pc;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if_instr_d = imem_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          if (imem_data == HALT_WORD) begin
            state_d = StHalt;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      StHalt: begin
        if_valid_d = 1'b0;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  assign imem_addr = pc_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign if_valid  = if_valid_q;
  assign halted    = (state_q == StHalt);

endmodule
